// File: rtl/window_border_mask_genr.sv
// ---------------------------------------------------------------------------
// window_border_mask_genr
//
// Frame-position tracker for the parallel-lane convolution datapath. It counts
// beats (NO_PARALLEL_UNITS pixels per beat) along each row and rows within a
// frame. A beat is accepted only when the tracker is running, in_valid is high
// and stall is low. From the registered position it derives active-low
// left/right border masks, which the line-buffer and window logic use to zero
// kernel taps that fall outside the image. It also derives row/frame boundary
// flags. The block sits beside the line buffers and is cleared with them by
// clrbuffer.
//
// Optional feature macro: BORDER_TB_EN
//   When defined, adds topend_mask / botend_mask for vertical border handling.
//   When undefined, those ports are absent and vertical borders are handled
//   outside this block.
//
// Ports
//   clk            in   rising-edge clock
//   res            in   asynchronous active-low reset
//   clrbuffer      in   synchronous clear: back to IDLE, counters 0
//   start          in   begin a frame (only honoured in IDLE)
//   in_valid       in   a beat is present this cycle
//   stall          in   downstream stall, blocks any advance
//   col_cnt        out  current beat index within the row
//   row_cnt        out  current row index within the frame
//   rowend_mask    out  bit i low when col_cnt == BPR-1-i (RUN only)
//   rowstart_mask  out  bit i low when col_cnt == i (RUN only)
//   row_last       out  last beat of the row (RUN only)
//   frame_last     out  last beat of the frame (RUN only)
//   busy           out  tracker is in RUN
//   frame_done     out  one-cycle pulse after the final beat is accepted
//   topend_mask    out  (BORDER_TB_EN) bit i low when row_cnt == i
//   botend_mask    out  (BORDER_TB_EN) bit i low when row_cnt == IM_HEIGHT-1-i
// ---------------------------------------------------------------------------
module window_border_mask_genr #(
  parameter int IM_LEN            = 520,
  parameter int IM_HEIGHT         = 520,
  parameter int KER_SIZE          = 3,
  parameter int NO_PARALLEL_UNITS = 4,
  parameter int COL_W             = 11,
  parameter int ROW_W             = 11
) (
  input  logic                clk,
  input  logic                res,
  input  logic                clrbuffer,
  input  logic                start,
  input  logic                in_valid,
  input  logic                stall,
  output logic [COL_W-1:0]    col_cnt,
  output logic [ROW_W-1:0]    row_cnt,
  output logic [KER_SIZE-2:0] rowend_mask,
  output logic [KER_SIZE-2:0] rowstart_mask,
  output logic                row_last,
  output logic                frame_last,
  output logic                busy,
`ifdef BORDER_TB_EN
  output logic [KER_SIZE-2:0] topend_mask,
  output logic [KER_SIZE-2:0] botend_mask,
`endif
  output logic                frame_done
);

  // Beats per row; all boundary constants are resolved at elaboration.
  localparam int BPR = IM_LEN / NO_PARALLEL_UNITS;
  localparam logic [COL_W-1:0] ColLast = COL_W'(BPR - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IM_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             advance;

  // State and position registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign advance = busy & in_valid & ~stall;

  // Next-state logic. clrbuffer outranks start and advance. Counters are
  // already zero whenever the tracker leaves RUN, so IDLE->RUN needs no reload.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (clrbuffer) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (advance) begin
            if (frame_last) begin
              state_d = DONE;
              col_d   = '0;
              row_d   = '0;
            end else if (row_last) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        DONE: state_d = IDLE;
        default: begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded straight from registered state, so the masks line up
  // with the counter value in the same cycle. Outside RUN every mask is all
  // ones and every flag is low.
  always_comb begin
    busy       = (state_q == RUN);
    frame_done = (state_q == DONE);
    col_cnt    = col_q;
    row_cnt    = row_q;
    row_last   = busy && (col_q == ColLast);
    frame_last = row_last && (row_q == RowLast);
    rowend_mask   = '1;
    rowstart_mask = '1;
    for (int i = 0; i < KER_SIZE - 1; i++) begin
      if (busy && (col_q == COL_W'(BPR - 1 - i))) rowend_mask[i]   = 1'b0;
      if (busy && (col_q == COL_W'(i)))           rowstart_mask[i] = 1'b0;
    end
  end

`ifdef BORDER_TB_EN
  // Vertical border masks, same active-low convention as the horizontal ones.
  always_comb begin
    topend_mask = '1;
    botend_mask = '1;
    for (int i = 0; i < KER_SIZE - 1; i++) begin
      if (busy && (row_q == ROW_W'(i)))                 topend_mask[i] = 1'b0;
      if (busy && (row_q == ROW_W'(IM_HEIGHT - 1 - i))) botend_mask[i] = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_window_border_mask_genr.sv
// ---------------------------------------------------------------------------
// tb_window_border_mask_genr
//
// Directed bench for window_border_mask_genr with a small image:
// IM_LEN=16, NO_PARALLEL_UNITS=4 (4 beats per row), IM_HEIGHT=3, KER_SIZE=3.
// Outputs are sampled on the falling clock edge; inputs change right after.
// ---------------------------------------------------------------------------
module tb_window_border_mask_genr;

  localparam int COL_W = 11;
  localparam int ROW_W = 11;

  logic             clk = 1'b0;
  logic             res;
  logic             clrbuffer;
  logic             start;
  logic             in_valid;
  logic             stall;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [1:0]       rowend_mask;
  logic [1:0]       rowstart_mask;
  logic             row_last;
  logic             frame_last;
  logic             busy;
  logic             frame_done;
`ifdef BORDER_TB_EN
  logic [1:0]       topend_mask;
  logic [1:0]       botend_mask;
`endif

  int checks   = 0;
  int failures = 0;

  window_border_mask_genr #(
    .IM_LEN(16), .IM_HEIGHT(3), .KER_SIZE(3), .NO_PARALLEL_UNITS(4),
    .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .res(res), .clrbuffer(clrbuffer), .start(start),
    .in_valid(in_valid), .stall(stall), .col_cnt(col_cnt), .row_cnt(row_cnt),
    .rowend_mask(rowend_mask), .rowstart_mask(rowstart_mask),
    .row_last(row_last), .frame_last(frame_last), .busy(busy),
`ifdef BORDER_TB_EN
    .topend_mask(topend_mask), .botend_mask(botend_mask),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // One clock: let the rising edge happen, then come back to the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    res = 1'b0; clrbuffer = 1'b0; start = 1'b0; in_valid = 1'b0; stall = 1'b0;
    tick();
    checks++;
    if (col_cnt !== 0 || row_cnt !== 0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        rowend_mask !== 2'b11 || rowstart_mask !== 2'b11 ||
        row_last !== 1'b0 || frame_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset: col=%0d row=%0d busy=%b done=%b re=%b rs=%b rl=%b fl=%b, want 0 0 0 0 11 11 0 0",
               col_cnt, row_cnt, busy, frame_done, rowend_mask, rowstart_mask, row_last, frame_last);
    end
`ifdef BORDER_TB_EN
    checks++;
    if (topend_mask !== 2'b11 || botend_mask !== 2'b11) begin
      failures++;
      $display("[TB] FAIL reset_tb_masks: top=%b bot=%b, want 11 11", topend_mask, botend_mask);
    end
`endif
    res = 1'b1;
    tick();
  endtask

  // Full frame with in_valid held high: checks every beat, then DONE and IDLE.
  task automatic test_full_frame();
    logic [1:0] reExp [4];
    logic [1:0] rsExp [4];
    logic [1:0] topExp [3];
    logic [1:0] botExp [3];
    reExp = '{2'b11, 2'b11, 2'b01, 2'b10};
    rsExp = '{2'b10, 2'b01, 2'b11, 2'b11};
    topExp = '{2'b10, 2'b01, 2'b11};
    botExp = '{2'b11, 2'b01, 2'b10};
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int b = 0; b < 12; b++) begin
      checks++;
      if (col_cnt !== COL_W'(b % 4) || row_cnt !== ROW_W'(b / 4) || busy !== 1'b1 ||
          rowend_mask !== reExp[b % 4] || rowstart_mask !== rsExp[b % 4] ||
          row_last !== (b % 4 == 3) || frame_last !== (b == 11) || frame_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL frame_beat%0d: col=%0d row=%0d busy=%b re=%b rs=%b rl=%b fl=%b done=%b, want %0d %0d 1 %b %b %b %b 0",
                 b, col_cnt, row_cnt, busy, rowend_mask, rowstart_mask, row_last, frame_last, frame_done,
                 b % 4, b / 4, reExp[b % 4], rsExp[b % 4], (b % 4 == 3), (b == 11));
      end
`ifdef BORDER_TB_EN
      checks++;
      if (topend_mask !== topExp[b / 4] || botend_mask !== botExp[b / 4]) begin
        failures++;
        $display("[TB] FAIL frame_tb_masks%0d: top=%b bot=%b, want %b %b",
                 b, topend_mask, botend_mask, topExp[b / 4], botExp[b / 4]);
      end
`endif
      tick();
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || col_cnt !== 0 || row_cnt !== 0 ||
        rowend_mask !== 2'b11 || rowstart_mask !== 2'b11 || row_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL frame_done_cycle: done=%b busy=%b col=%0d row=%0d re=%b rs=%b rl=%b, want 1 0 0 0 11 11 0",
               frame_done, busy, col_cnt, row_cnt, rowend_mask, rowstart_mask, row_last);
    end
    start = 1'b1;  // ignored in DONE
    tick();
    start = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || col_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL frame_idle_after: done=%b busy=%b col=%0d, want 0 0 0", frame_done, busy, col_cnt);
    end
    in_valid = 1'b0;
    tick();
  endtask

  // Stall at the last beat of row 0: everything held, wrap on first free beat.
  task automatic test_stall();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    repeat (3) tick();
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (col_cnt !== 3 || row_cnt !== 0 || rowend_mask !== 2'b10 ||
          rowstart_mask !== 2'b11 || row_last !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d: col=%0d row=%0d re=%b rs=%b rl=%b busy=%b, want 3 0 10 11 1 1",
                 s, col_cnt, row_cnt, rowend_mask, rowstart_mask, row_last, busy);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (col_cnt !== 0 || row_cnt !== 1 || rowstart_mask !== 2'b10) begin
      failures++;
      $display("[TB] FAIL stall_wrap: col=%0d row=%0d rs=%b, want 0 1 10", col_cnt, row_cnt, rowstart_mask);
    end
  endtask

  // Continues from row 1 col 0: clear at row 1 col 2 while start is high.
  task automatic test_clear();
    tick();
    tick();
    checks++;
    if (col_cnt !== 2 || row_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL clear_setup: col=%0d row=%0d, want 2 1", col_cnt, row_cnt);
    end
    clrbuffer = 1'b1;
    start = 1'b1;
    tick();
    clrbuffer = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || col_cnt !== 0 || row_cnt !== 0 || frame_done !== 1'b0 ||
        rowend_mask !== 2'b11 || rowstart_mask !== 2'b11) begin
      failures++;
      $display("[TB] FAIL clear_state: busy=%b col=%0d row=%0d done=%b re=%b rs=%b, want 0 0 0 0 11 11",
               busy, col_cnt, row_cnt, frame_done, rowend_mask, rowstart_mask);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || col_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL clear_idle_valid: busy=%b col=%0d, want 0 0", busy, col_cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || col_cnt !== 0 || row_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL clear_restart: busy=%b col=%0d row=%0d, want 1 0 0", busy, col_cnt, row_cnt);
    end
    tick();
    checks++;
    if (col_cnt !== 1 || row_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL clear_restart_adv: col=%0d row=%0d, want 1 0", col_cnt, row_cnt);
    end
    in_valid = 1'b0;
    clrbuffer = 1'b1;
    tick();
    clrbuffer = 1'b0;
  endtask

  // in_valid alternates 1/0; the frame must take exactly 12 accepted beats.
  task automatic test_valid_toggle();
    int accepted;
    int cycles;
    bit seenDone;
    accepted = 0;
    seenDone = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (cycles = 0; cycles < 60 && !seenDone; cycles++) begin
      in_valid = (cycles % 2 == 0);
      if (cycles % 2 == 0) accepted++;
      tick();
      if (frame_done === 1'b1) seenDone = 1'b1;
      else begin
        checks++;
        if (col_cnt !== COL_W'(accepted % 4) || row_cnt !== ROW_W'(accepted / 4)) begin
          failures++;
          $display("[TB] FAIL toggle_pos%0d: col=%0d row=%0d, want %0d %0d",
                   cycles, col_cnt, row_cnt, accepted % 4, accepted / 4);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!seenDone || accepted !== 12 || cycles !== 23) begin
      failures++;
      $display("[TB] FAIL toggle_done: seen=%b accepted=%0d cycles=%0d, want 1 12 23", seenDone, accepted, cycles);
    end
    tick();
  endtask

  // Reset asserted between clock edges must take effect immediately.
  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    repeat (6) tick();
    checks++;
    if (col_cnt !== 2 || row_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL areset_setup: col=%0d row=%0d, want 2 1", col_cnt, row_cnt);
    end
    #2 res = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || col_cnt !== 0 || row_cnt !== 0 || frame_done !== 1'b0 ||
        rowend_mask !== 2'b11 || rowstart_mask !== 2'b11) begin
      failures++;
      $display("[TB] FAIL areset_now: busy=%b col=%0d row=%0d done=%b re=%b rs=%b, want 0 0 0 0 11 11",
               busy, col_cnt, row_cnt, frame_done, rowend_mask, rowstart_mask);
    end
    in_valid = 1'b0;
    @(negedge clk);
    res = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || col_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL areset_release: busy=%b col=%0d, want 0 0", busy, col_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_stall();
    test_clear();
    test_valid_toggle();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
